// File: rtl/axis_arb_mux.sv
// axis_arb_mux: N-to-1 AXI-Stream multiplexer with packet-aware arbitration.
//
// The source is picked either from an external select (ARB_MODE=0) or by
// round-robin (ARB_MODE=1). The beat is then captured in a registered output
// stage. When packet locking is enabled, the grant is held from a packet's
// first accepted beat until its tlast beat is accepted.
//
// Build option: define AXIS_ARB_MUX_PKT_LOCK_EN to enable packet locking.
// Without it, LOCKED is never entered and arbitration reruns on every beat.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | no packet in flight; grant recomputed from requests each cycle
// LOCKED | mid-packet; grant held on r_grant until the tlast handshake

module axis_arb_mux #(
    parameter int N_CH     = 4,
    parameter int DATA_W   = 32,
    parameter int ARB_MODE = 1,
    parameter int SEL_W    = $clog2(N_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [SEL_W-1:0]         sel,
    input  logic [N_CH*DATA_W-1:0]   s_tdata,
    input  logic [N_CH-1:0]          s_tvalid,
    input  logic [N_CH-1:0]          s_tlast,
    output logic [N_CH-1:0]          s_tready,
    output logic [DATA_W-1:0]        m_tdata,
    output logic                     m_tvalid,
    output logic                     m_tlast,
    input  logic                     m_tready,
    output logic [N_CH-1:0]          grant,
    output logic                     busy
);

    localparam int PTR_W = $clog2(N_CH);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [DATA_W-1:0]   r_m_tdata;
    logic                r_m_tvalid;
    logic                r_m_tlast;
    logic [N_CH-1:0]     r_grant;
    logic [PTR_W-1:0]    r_rr_ptr;

    logic                w_load;
    logic [N_CH-1:0]     w_rr_hi;
    logic [N_CH-1:0]     w_rr_cand;
    logic [N_CH-1:0]     w_rr_grant;
    logic [N_CH-1:0]     w_sel_grant;
    logic [N_CH-1:0]     w_arb_grant;
    logic [N_CH-1:0]     w_cur_grant;
    logic [N_CH-1:0]     w_s_tready;
    logic                w_busy;
    logic [N_CH-1:0]     w_hs_vec;
    logic                w_hs;
    logic [PTR_W-1:0]    w_hs_idx;
    logic [DATA_W-1:0]   w_hs_data;
    logic                w_hs_last;
    logic [PTR_W-1:0]    w_ptr_nxt;

    // The output register can take a new beat when it is empty or draining.
    assign w_load = !r_m_tvalid || m_tready;

    // Round-robin: requests at or above the pointer win first; if none, wrap
    // to the whole request vector. The lowest set bit of the candidate set
    // is then isolated, which gives the upward search with wrap.
    always_comb begin
        w_rr_hi = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_rr_hi[i] = s_tvalid[i] && (PTR_W'(i) >= r_rr_ptr);
        end
    end

    assign w_rr_cand  = (|w_rr_hi) ? w_rr_hi : s_tvalid;
    assign w_rr_grant = w_rr_cand & (~w_rr_cand + N_CH'(1));

    // External select: a select value with no matching channel grants nothing.
    always_comb begin
        w_sel_grant = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_sel_grant[i] = s_tvalid[i] && (sel == SEL_W'(i));
        end
    end

    assign w_arb_grant = (ARB_MODE == 0) ? w_sel_grant : w_rr_grant;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic: enter LOCKED on a non-last beat, leave on tlast.
    always_comb begin
        w_state_nxt = r_state;
`ifdef AXIS_ARB_MUX_PKT_LOCK_EN
        case (r_state)
            ST_IDLE: begin
                if (w_hs && !w_hs_last) begin
                    w_state_nxt = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (w_hs && w_hs_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
`else
        w_state_nxt = ST_IDLE;
`endif
    end

    // FSM outputs: held grant while LOCKED, ready gated by the output stage
    // (this is the deliberate combinational m_tready -> s_tready path).
    always_comb begin
        w_cur_grant = w_arb_grant;
        w_busy      = 1'b0;
        if (r_state == ST_LOCKED) begin
            w_cur_grant = r_grant;
            w_busy      = 1'b1;
        end
        w_s_tready = (rst || !w_load) ? '0 : w_cur_grant;
    end

    // Select data/last/index of the granted channel; the grant is one-hot.
    always_comb begin
        w_hs_vec  = w_s_tready & s_tvalid;
        w_hs_idx  = '0;
        w_hs_data = '0;
        w_hs_last = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (w_cur_grant[i]) begin
                w_hs_idx  = PTR_W'(i);
                w_hs_data = s_tdata[i*DATA_W +: DATA_W];
                w_hs_last = s_tlast[i];
            end
        end
    end

    assign w_hs      = |w_hs_vec;
    assign w_ptr_nxt = (w_hs_idx == PTR_W'(N_CH - 1)) ? '0 : w_hs_idx + PTR_W'(1);

    // Output stage: load on handshake, clear valid when drained with no new beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_m_tvalid <= 1'b0;
            r_m_tdata  <= '0;
            r_m_tlast  <= 1'b0;
        end else if (w_load) begin
            r_m_tvalid <= w_hs;
            if (w_hs) begin
                r_m_tdata <= w_hs_data;
                r_m_tlast <= w_hs_last;
            end
        end
    end

    // Grant and round-robin pointer bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant  <= '0;
            r_rr_ptr <= '0;
        end else if (w_hs) begin
`ifdef AXIS_ARB_MUX_PKT_LOCK_EN
            // The pointer moves only when a packet completes.
            if (w_hs_last) begin
                r_grant  <= '0;
                r_rr_ptr <= w_ptr_nxt;
            end else begin
                r_grant  <= w_cur_grant;
            end
`else
            // Without locking every beat is its own arbitration round.
            r_grant  <= w_cur_grant;
            r_rr_ptr <= w_ptr_nxt;
`endif
        end
    end

    assign m_tdata  = r_m_tdata;
    assign m_tvalid = r_m_tvalid;
    assign m_tlast  = r_m_tlast;
    assign grant    = r_grant;
    assign s_tready = w_s_tready;
    assign busy     = w_busy;

endmodule

// File: tb/tb_axis_arb_mux.sv
// Bench for axis_arb_mux: one round-robin and one external-select instance
// share the stimulus; an `active` flag picks which one is being scored.
// Expected beats are queued when the stimulus is set up and popped as
// output beats are accepted downstream.

module tb_axis_arb_mux;

    logic          clk = 1'b0;
    logic          rst;
    logic [127:0]  s_tdata;
    logic [3:0]    s_tvalid;
    logic [3:0]    s_tlast;
    logic          m_tready;
    logic [1:0]    sel_r;
    logic [2:0]    sel_s;

    logic [3:0]    rr_s_tready, sl_s_tready;
    logic [31:0]   rr_m_tdata, sl_m_tdata;
    logic          rr_m_tvalid, sl_m_tvalid;
    logic          rr_m_tlast, sl_m_tlast;
    logic [3:0]    rr_grant, sl_grant;
    logic          rr_busy, sl_busy;

    logic          active;
    logic          mon_en;
    logic [3:0]    a_s_tready;
    logic [31:0]   a_m_tdata;
    logic          a_m_tvalid;
    logic          a_m_tlast;

    int            n_cmp = 0;
    int            n_err = 0;

    logic [32:0]   exp_q[$];
    logic [32:0]   src_mem [4][8];
    int            src_len [4];
    int            src_pos [4];

    typedef struct {
        logic [2:0]  sel;
        logic [3:0]  tv;
        logic [3:0]  exp_rdy;
        logic [31:0] exp_data;
    } vec_t;
    vec_t vecs [7];

    always #5 clk = ~clk;

    axis_arb_mux #(.N_CH(4), .DATA_W(32), .ARB_MODE(1)) dut_rr (
        .clk(clk), .rst(rst), .sel(sel_r),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(rr_s_tready),
        .m_tdata(rr_m_tdata), .m_tvalid(rr_m_tvalid), .m_tlast(rr_m_tlast), .m_tready(m_tready),
        .grant(rr_grant), .busy(rr_busy)
    );

    axis_arb_mux #(.N_CH(4), .DATA_W(32), .ARB_MODE(0), .SEL_W(3)) dut_sel (
        .clk(clk), .rst(rst), .sel(sel_s),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(sl_s_tready),
        .m_tdata(sl_m_tdata), .m_tvalid(sl_m_tvalid), .m_tlast(sl_m_tlast), .m_tready(m_tready),
        .grant(sl_grant), .busy(sl_busy)
    );

    assign a_s_tready = active ? sl_s_tready : rr_s_tready;
    assign a_m_tdata  = active ? sl_m_tdata  : rr_m_tdata;
    assign a_m_tvalid = active ? sl_m_tvalid : rr_m_tvalid;
    assign a_m_tlast  = active ? sl_m_tlast  : rr_m_tlast;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add_beat(input int ch, input logic [31:0] d, input logic l);
        src_mem[ch][src_len[ch]] = {l, d};
        src_len[ch]++;
    endtask

    task automatic clear_src();
        for (int i = 0; i < 4; i++) begin
            src_len[i] = 0;
            src_pos[i] = 0;
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < 4; i++) begin
            if (src_pos[i] < src_len[i]) begin
                s_tvalid[i]          = 1'b1;
                s_tdata[i*32 +: 32]  = src_mem[i][src_pos[i]][31:0];
                s_tlast[i]           = src_mem[i][src_pos[i]][32];
            end else begin
                s_tvalid[i]          = 1'b0;
                s_tdata[i*32 +: 32]  = '0;
                s_tlast[i]           = 1'b0;
            end
        end
    endtask

    // One clock: score the output beat at the falling edge, note which input
    // handshakes will happen, then advance the sources after the rising edge.
    task automatic step();
        logic [3:0]  hs;
        logic [32:0] e;
        @(negedge clk);
        if (mon_en && a_m_tvalid && m_tready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_extra: got %h expected no beat", {a_m_tlast, a_m_tdata});
            end else begin
                e = exp_q.pop_front();
                if ({a_m_tlast, a_m_tdata} !== e) begin
                    n_err++;
                    $display("FAIL sb_beat: got %h expected %h", {a_m_tlast, a_m_tdata}, e);
                end
            end
        end
        hs = s_tvalid & a_s_tready;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (hs[i]) src_pos[i]++;
        end
        drive_inputs();
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        rst    = 1'b1;
        clear_src();
        drive_inputs();
        step();
        step();
        rst = 1'b0;
        exp_q.delete();
        mon_en = 1'b1;
    endtask

    initial begin
        logic exp_busy [6];

        vecs[0] = '{3'd0, 4'b1111, 4'b0001, 32'h50};
        vecs[1] = '{3'd2, 4'b1111, 4'b0100, 32'h52};
        vecs[2] = '{3'd2, 4'b1011, 4'b0000, 32'h0};
        vecs[3] = '{3'd3, 4'b1000, 4'b1000, 32'h53};
        vecs[4] = '{3'd7, 4'b1111, 4'b0000, 32'h0};
        vecs[5] = '{3'd4, 4'b1111, 4'b0000, 32'h0};
        vecs[6] = '{3'd1, 4'b0010, 4'b0010, 32'h51};

        rst      = 1'b1;
        m_tready = 1'b1;
        sel_r    = 2'd0;
        sel_s    = 3'd0;
        active   = 1'b0;
        mon_en   = 1'b0;
        s_tdata  = '0;
        s_tvalid = '0;
        s_tlast  = '0;

        // Reset held with every channel requesting.
        clear_src();
        for (int i = 0; i < 4; i++) add_beat(i, 32'h77 + 32'(i), 1'b0);
        drive_inputs();
        for (int c = 0; c < 3; c++) begin
            step();
            chk("rst_rr", {rr_m_tvalid, rr_s_tready, rr_grant, rr_busy}, 64'd0);
            chk("rst_sel", {sl_m_tvalid, sl_s_tready, sl_grant, sl_busy}, 64'd0);
        end
        chk("rst_vals", {rr_m_tdata, rr_m_tlast, sl_m_tdata, sl_m_tlast}, 64'd0);
        clear_src();
        drive_inputs();
        rst    = 1'b0;
        mon_en = 1'b1;

        // Round-robin fairness with 1-beat packets, one beat per cycle.
        do_reset();
        active = 1'b0;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) begin
                add_beat(i, 32'h10 + 32'(i), 1'b1);
                exp_q.push_back({1'b1, 32'h10 + 32'(i)});
            end
        end
        drive_inputs();
        repeat (9) step();
        chk("rr_throughput", 64'(exp_q.size()), 64'd0);
        repeat (2) step();
`ifdef AXIS_ARB_MUX_PKT_LOCK_EN
        chk("rr_grant_end", 64'(rr_grant), 64'h0);
`else
        chk("rr_grant_end", 64'(rr_grant), 64'h8);
`endif

        // Packet on channel 1 with channel 2 requesting throughout.
        do_reset();
        for (int k = 0; k < 4; k++) add_beat(1, 32'hA0 + 32'(k), k == 3);
        add_beat(2, 32'hB0, 1'b0);
        add_beat(2, 32'hB1, 1'b1);
`ifdef AXIS_ARB_MUX_PKT_LOCK_EN
        exp_q.push_back({1'b0, 32'hA0});
        exp_q.push_back({1'b0, 32'hA1});
        exp_q.push_back({1'b0, 32'hA2});
        exp_q.push_back({1'b1, 32'hA3});
        exp_q.push_back({1'b0, 32'hB0});
        exp_q.push_back({1'b1, 32'hB1});
        exp_busy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_q.push_back({1'b0, 32'hA0});
        exp_q.push_back({1'b0, 32'hB0});
        exp_q.push_back({1'b0, 32'hA1});
        exp_q.push_back({1'b1, 32'hB1});
        exp_q.push_back({1'b0, 32'hA2});
        exp_q.push_back({1'b1, 32'hA3});
        exp_busy = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
        drive_inputs();
        for (int k = 0; k < 6; k++) begin
            step();
            chk($sformatf("lock_busy%0d", k), 64'(rr_busy), 64'(exp_busy[k]));
        end
        repeat (3) step();
        chk("lock_drain", 64'(exp_q.size()), 64'd0);

        // Backpressure mid-packet.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            add_beat(0, 32'hC0 + 32'(k), k == 3);
            exp_q.push_back({k == 3, 32'hC0 + 32'(k)});
        end
        drive_inputs();
        step();
        step();
        m_tready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("bp_hold%0d", c), {rr_m_tvalid, rr_m_tdata, rr_s_tready}, {1'b1, 32'hC1, 4'b0000});
            step();
        end
        m_tready = 1'b1;
        repeat (4) step();
        chk("bp_drain", 64'(exp_q.size()), 64'd0);

        // External select: table of single-beat requests.
        do_reset();
        active = 1'b1;
        for (int v = 0; v < 7; v++) begin
            clear_src();
            for (int i = 0; i < 4; i++) begin
                if (vecs[v].tv[i]) add_beat(i, 32'h50 + 32'(i), 1'b1);
            end
            sel_s = vecs[v].sel;
            drive_inputs();
            #1;
            chk($sformatf("sel_vec%0d", v), 64'(sl_s_tready), 64'(vecs[v].exp_rdy));
            if (vecs[v].exp_rdy != 4'b0000) exp_q.push_back({1'b1, vecs[v].exp_data});
            step();
        end
        clear_src();
        drive_inputs();
        repeat (2) step();
        chk("sel_table_drain", 64'(exp_q.size()), 64'd0);

        // External select: select moved off channel 2 mid-packet.
        do_reset();
        for (int k = 0; k < 3; k++) add_beat(2, 32'hD0 + 32'(k), k == 2);
        add_beat(0, 32'hE0, 1'b1);
        sel_s = 3'd2;
`ifdef AXIS_ARB_MUX_PKT_LOCK_EN
        exp_q.push_back({1'b0, 32'hD0});
        exp_q.push_back({1'b0, 32'hD1});
        exp_q.push_back({1'b1, 32'hD2});
        exp_q.push_back({1'b1, 32'hE0});
`else
        exp_q.push_back({1'b0, 32'hD0});
        exp_q.push_back({1'b1, 32'hE0});
`endif
        drive_inputs();
        step();
        chk("sel_grant_d0", 64'(sl_grant), 64'h4);
        sel_s = 3'd0;
        repeat (6) step();
        chk("sel_switch", 64'(exp_q.size()), 64'd0);
`ifndef AXIS_ARB_MUX_PKT_LOCK_EN
        exp_q.push_back({1'b0, 32'hD1});
        exp_q.push_back({1'b1, 32'hD2});
`endif
        sel_s = 3'd2;
        repeat (4) step();
        chk("sel_resume", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/axis_arb_mux.md
# axis_arb_mux

Parametrised N-to-1 AXI-Stream multiplexer with packet-aware arbitration and a registered output stage. It merges `N_CH` upstream streams onto one downstream stream, choosing the source either from an external select or by round-robin. Once a packet is granted, the grant is held until its `tlast` beat is accepted. It replaces the fixed 2:1 combinational stream mux wherever more channels, packet integrity or a registered output is needed.

## Interface
Parameters:
- `N_CH`, default 4: number of input channels, 2..16.
- `DATA_W`, default 32: tdata width in bits.
- `ARB_MODE`, default 1: 0 = external `sel`, 1 = round-robin.
- `SEL_W`, default `$clog2(N_CH)`: width of `sel`.

Ports:
- `clk`  in  1: single clock; all logic is on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `sel`  in  SEL_W: channel select; used only when `ARB_MODE`=0.
- `s_tdata`  in  N_CH*DATA_W: input data; channel i occupies bits [i*DATA_W +: DATA_W].
- `s_tvalid`  in  N_CH: per-channel valid.
- `s_tlast`  in  N_CH: per-channel end of packet.
- `s_tready`  out  N_CH: per-channel ready.
- `m_tdata`  out  DATA_W: output data, registered.
- `m_tvalid`  out  1: output valid, registered.
- `m_tlast`  out  1: output last, registered.
- `m_tready`  in  1: downstream ready.
- `grant`  out  N_CH: one-hot current grant, registered; 0 when no grant is held.
- `busy`  out  1: high while in LOCKED.

## Operation
- The output register loads when `load` = !`m_tvalid` || `m_tready`.
- `s_tready[i]` = `cur_grant[i]` && `load`. Non-granted channels always see `s_tready`=0.
- The input handshake on channel g copies `s_tdata[g]` and `s_tlast[g]` into `m_tdata` and `m_tlast`, and sets `m_tvalid`.
- If `load` is high and no input handshake occurs, `m_tvalid` clears.
- The FSM has two states, IDLE and LOCKED.
- In IDLE, `cur_grant` is computed combinationally from requests:
  - `ARB_MODE`=1: the first valid channel at or after `rr_ptr`, searching upward with wrap.
  - `ARB_MODE`=0: channel `sel`, only if `s_tvalid[sel]` is high. A `sel` value >= `N_CH` grants nothing.
- IDLE transitions:
  - Handshake on g with `s_tlast`=0 -> LOCKED; `grant` <= onehot(g).
  - Handshake on g with `s_tlast`=1 -> stay in IDLE; `rr_ptr` <= (g+1) mod `N_CH`.
- In LOCKED, `cur_grant` = `grant`. Other channels' requests and `sel` changes are ignored.
- LOCKED exit: handshake with `s_tlast`=1 -> IDLE; `grant` <= 0; `rr_ptr` <= (g+1) mod `N_CH`.
- If the granted channel drops `s_tvalid` mid-packet, the block stays LOCKED with no timeout.
- `rr_ptr` advances only on packet completion, never on a single non-last beat.

## Timing
- Reset values: `m_tvalid`=0, `m_tdata`=0, `m_tlast`=0, `grant`=0, `busy`=0, `rr_ptr`=0, state=IDLE. `s_tready`=0 while `rst`=1.
- Latency: an input beat accepted in cycle t appears on `m_*` in cycle t+1.
- Throughput: 1 beat per cycle while `m_tready`=1.
- No bubble between packets: the cycle after a `tlast` handshake is IDLE, so a waiting channel is granted and can hand off in that same cycle.
- When `m_tvalid`=1 and `m_tready`=0, `m_tdata` and `m_tlast` hold stable and all `s_tready` are 0.
- There is a combinational path from `m_tready` to `s_tready` by design.
- Reset mid-packet: any partial packet is abandoned, and the held output beat is dropped (`m_tvalid`=0 the cycle after `rst`).

## Configuration
- Macro: `AXIS_ARB_MUX_PKT_LOCK_EN`.
- Defined: packet locking as described above.
- Undefined: LOCKED is never entered and `busy`=0. Arbitration reruns every beat.
  - `rr_ptr` advances after every accepted beat.
  - `grant` shows the channel of the last accepted beat.
  - `tlast` passes through but does not affect arbitration.

## Test plan
- Reset: hold `rst`=1 for 3 cycles with all `s_tvalid` high -> `m_tvalid`=0, `s_tready`=0, `grant`=0 throughout.
- Round-robin fairness: `ARB_MODE`=1, channels 0..3 each send one 1-beat packet (`tdata`=0x10+i, `tlast`=1), continuously valid -> output order 0x10, 0x11, 0x12, 0x13, 0x10…, one beat per cycle.
- Packet lock: channel 1 sends a 4-beat packet (0xA0..0xA3) while channel 2 is valid throughout -> all four A-beats appear contiguously, then channel 2's first beat. `busy` is high during beats 1-3.
- Backpressure: `m_tready` low for 5 cycles mid-packet -> `m_tdata` stable, all `s_tready`=0; no beat lost or duplicated after release.
- External select: `ARB_MODE`=0, `sel`=2 during a 3-beat packet on channel 2, with `sel` switched to 0 after beat 1 -> all 3 beats come from channel 2, then channel 0 is granted. `sel`=7 with `N_CH`=4 -> no grant.
- Macro undefined: repeat the packet-lock test -> channel 1 and channel 2 beats interleave 1:1.
